// File: rtl/data_gearbox.sv
// data_gearbox: converts a stream of IN_WIDTH-bit words into OUT_WIDTH-bit words
// for any width ratio, MSB-first on both sides, with valid/ready flow control.
// Optional framing (first/last markers, zero padding of the final word) is
// compiled in when the macro GEARBOX_FRAME_EN is defined.
//
// Handshake: a word moves on a side only in a cycle where valid and ready are
// both high at the rising edge; valid never waits for ready, in_ready depends
// only on registered state, and out_data/out_first/out_last hold while
// out_valid=1 and out_ready=0.
module data_gearbox #(
    parameter  int IN_WIDTH  = 32,
    parameter  int OUT_WIDTH = 7,
    localparam int CAP       = IN_WIDTH + OUT_WIDTH,
    localparam int LVL_W     = $clog2(CAP + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_first,
    output logic                 out_last,
    output logic [LVL_W-1:0]     level
);

    localparam logic [LVL_W-1:0] IN_L  = LVL_W'(IN_WIDTH);
    localparam logic [LVL_W-1:0] OUT_L = LVL_W'(OUT_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_STREAM = 2'd2,
        S_TAIL   = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           rst_sync_q;
    logic                 rst_int_n;
    logic [CAP-1:0]       buf_q, buf_d, buf_shift;
    logic [CAP-1:0]       ins_word;
    logic [LVL_W-1:0]     level_q, lvl_rem, lvl_next;
    logic                 in_fire, out_fire;
    logic                 tail_pend, start_tail, last_word;

    // Reset synchroniser: asserts immediately, releases two edges after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    assign tail_pend = (state_q == S_TAIL);

    // Handshake flags derived only from registered level and state.
    always_comb begin
        in_ready  = (level_q <= OUT_L) && !tail_pend;
        out_valid = (level_q >= OUT_L) || (tail_pend && (level_q != '0));
    end

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Valid bits sit MSB-aligned in buf_q; everything below level is kept zero,
    // so the head slice is already zero-padded when the tail is short.
    assign out_data = buf_q[CAP-1 -: OUT_WIDTH];
    assign level    = level_q;

`ifdef GEARBOX_FRAME_EN
    logic first_pend_q;

    assign start_tail = in_fire && in_last;
    assign last_word  = tail_pend && (level_q <= OUT_L);
    assign out_last   = out_valid && last_word;
    assign out_first  = out_valid && first_pend_q;

    // The next emitted word opens a frame after reset or after a frame's last word.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n)    first_pend_q <= 1'b1;
        else if (out_fire) first_pend_q <= last_word;
    end
`else
    logic unused_in_last;

    assign unused_in_last = in_last;
    assign start_tail     = 1'b0;
    assign last_word      = 1'b0;
    assign out_last       = 1'b0;
    assign out_first      = 1'b0;
`endif

    // Datapath: drop the emitted word, then append the new word behind what remains.
    always_comb begin
        lvl_rem   = level_q;
        buf_shift = buf_q;
        if (out_fire) begin
            lvl_rem   = (level_q >= OUT_L) ? (level_q - OUT_L) : '0;
            buf_shift = buf_q << OUT_WIDTH;
        end
        ins_word = {in_data, {OUT_WIDTH{1'b0}}};
        lvl_next = lvl_rem;
        buf_d    = buf_shift;
        if (in_fire) begin
            lvl_next = lvl_rem + IN_L;
            buf_d    = buf_shift | (ins_word >> lvl_rem);
        end
    end

    // Next-state: a pending tail holds until its last word leaves; otherwise the
    // state simply reflects the new fill level.
    always_comb begin
        state_d = state_q;
        if (tail_pend) begin
            if (out_fire && last_word) state_d = S_IDLE;
        end else if (start_tail) begin
            state_d = S_TAIL;
        end else if (lvl_next == '0) begin
            state_d = S_IDLE;
        end else if (lvl_next < OUT_L) begin
            state_d = S_FILL;
        end else begin
            state_d = S_STREAM;
        end
    end

    // State, buffer and fill-level registers.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q <= S_IDLE;
            buf_q   <= '0;
            level_q <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            level_q <= lvl_next;
        end
    end

endmodule
